// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - MIPS writeback stage: result capture, load alignment/extension, register-file write strobe
// Optional retire counter enabled by defining WRITEBACK_RETIRE_CNT_EN.
module writeback_stage #(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 32
) (
  input  logic              wb_clk,
  input  logic              wb_rst,
  input  logic              wb_i_ce,
  input  logic              wb_i_stall,
  input  logic              wb_i_flush,
  input  logic              wb_i_reg_wr,
  input  logic              wb_i_reg_dst,
  input  logic [AWIDTH-1:0] wb_i_addr_rd,
  input  logic [AWIDTH-1:0] wb_i_addr_rt,
  input  logic              wb_i_mem_to_reg,
  input  logic [DWIDTH-1:0] wb_i_alu_result,
  input  logic [DWIDTH-1:0] wb_i_mem_data,
  input  logic [1:0]        wb_i_mem_size,
  input  logic              wb_i_mem_unsigned,
  output logic              wb_o_reg_wr,
  output logic              wb_o_reg_dst,
  output logic [DWIDTH-1:0] wb_o_data_rd,
  output logic [AWIDTH-1:0] wb_o_addr_wr,
  output logic              wb_o_ce,
  output logic              wb_o_misalign,
  output logic [31:0]       wb_o_retire_cnt
);

  typedef enum logic {S_EMPTY, S_VALID} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_capture;
  logic [1:0]        w_off;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [DWIDTH-1:0] w_load;
  logic              w_mis_raw;
  logic              w_mis;
  logic [DWIDTH-1:0] w_wdata;
  logic [AWIDTH-1:0] w_addr;
  logic              w_wr_ok;

  logic              r_wr_ok;
  logic              r_mis;
  logic              r_reg_dst;
  logic [DWIDTH-1:0] r_data;
  logic [AWIDTH-1:0] r_addr;

  // Flush dominates stall, which dominates ce.
  assign w_capture = wb_i_ce & ~wb_i_stall & ~wb_i_flush;
  assign w_off     = wb_i_alu_result[1:0];

  // Little-endian lane select, extension and misalignment detection for loads.
  always_comb begin
    w_byte    = wb_i_mem_data[{w_off, 3'b000} +: 8];
    w_half    = wb_i_mem_data[{w_off[1], 4'b0000} +: 16];
    w_load    = wb_i_mem_data;
    w_mis_raw = 1'b0;
    case (wb_i_mem_size)
      2'b00: begin
        w_load = {{(DWIDTH-8){~wb_i_mem_unsigned & w_byte[7]}}, w_byte};
      end
      2'b01: begin
        w_load    = {{(DWIDTH-16){~wb_i_mem_unsigned & w_half[15]}}, w_half};
        w_mis_raw = w_off[0];
      end
      default: begin
        w_load    = wb_i_mem_data;
        w_mis_raw = (w_off != 2'b00);
      end
    endcase
  end

  // ALU results never count as misaligned; writes to $0 or misaligned loads are suppressed.
  assign w_mis   = wb_i_mem_to_reg & w_mis_raw;
  assign w_wdata = wb_i_mem_to_reg ? w_load : wb_i_alu_result;
  assign w_addr  = wb_i_reg_dst ? wb_i_addr_rd : wb_i_addr_rt;
  assign w_wr_ok = wb_i_reg_wr & (w_addr != '0) & ~w_mis;

  // State register: EMPTY/VALID tracks whether the held bundle retires this cycle.
  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) r_state <= S_EMPTY;
    else         r_state <= w_state_nxt;
  end

  // Next state and strobe outputs; strobes are only live in VALID.
  always_comb begin
    w_state_nxt   = S_EMPTY;
    wb_o_ce       = 1'b0;
    wb_o_reg_wr   = 1'b0;
    wb_o_misalign = 1'b0;
    if (w_capture) w_state_nxt = S_VALID;
    if (r_state == S_VALID) begin
      wb_o_ce       = 1'b1;
      wb_o_reg_wr   = r_wr_ok;
      wb_o_misalign = r_mis;
    end
  end

  // Captured bundle; holds through stall, flush and idle cycles.
  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      r_wr_ok   <= 1'b0;
      r_mis     <= 1'b0;
      r_reg_dst <= 1'b0;
      r_data    <= '0;
      r_addr    <= '0;
    end else if (w_capture) begin
      r_wr_ok   <= w_wr_ok;
      r_mis     <= w_mis;
      r_reg_dst <= wb_i_reg_dst;
      r_data    <= w_wdata;
      r_addr    <= w_addr;
    end
  end

  assign wb_o_reg_dst = r_reg_dst;
  assign wb_o_data_rd = r_data;
  assign wb_o_addr_wr = r_addr;

`ifdef WRITEBACK_RETIRE_CNT_EN
  logic [31:0] r_retire_cnt;

  // Count every cycle an instruction retires; wraps naturally.
  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst)      r_retire_cnt <= 32'd0;
    else if (wb_o_ce) r_retire_cnt <= r_retire_cnt + 32'd1;
  end

  assign wb_o_retire_cnt = r_retire_cnt;
`else
  assign wb_o_retire_cnt = 32'd0;
`endif

endmodule
